// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port, with an in-order ID FIFO for response routing.
// Optional stall counter output enabled by defining MEM_ARB_STALL_CNT_EN.
module mem_req_arbiter #(
    parameter int N_REQ   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ-1:0]       we_i,
    input  logic [N_REQ-1:0][31:0] addr_i,
    input  logic [N_REQ-1:0][31:0] wdata_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [31:0]            mem_rdata_i,
    output logic                   busy_o,
    output logic                   err_o
`ifdef MEM_ARB_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt_o
`endif
);

    localparam int IW = $clog2(N_REQ);
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    // state   | meaning
    // ST_ARB  | free arbitration, winner follows the round-robin search
    // ST_LOCK | downstream stalled, mux pinned to sel_q until accepted
    typedef enum logic {ST_ARB, ST_LOCK} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    sel_q, sel_d;
    logic [IW-1:0]    win_idx, sel_idx;
    logic [N_REQ-1:0] req_rot;
    logic             win_vld, sel_vld;
    logic             grant_done, push, pop;
    logic             fifo_full, fifo_empty;
    logic [IW-1:0]    fifo_q [MAX_OUT];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Rotate requests so bit 0 is the current priority holder; lowest set bit wins.
    always_comb begin
        req_rot = N_REQ'({req_i, req_i} >> ptr_q);
        win_vld = 1'b0;
        win_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(ptr_q) + j) % N_REQ);
            end
        end
    end

    assign fifo_full  = (cnt_q == CW'(MAX_OUT));
    assign fifo_empty = (cnt_q == '0);

    always_comb begin
        sel_idx     = (state_q == ST_LOCK) ? sel_q : win_idx;
        sel_vld     = (state_q == ST_LOCK) || win_vld;
        mem_req_o   = !rst_i && sel_vld && req_i[sel_idx] && !fifo_full;
        mem_we_o    = sel_vld ? we_i[sel_idx] : 1'b0;
        mem_addr_o  = sel_vld ? addr_i[sel_idx] : 32'h0;
        mem_wdata_o = sel_vld ? wdata_i[sel_idx] : 32'h0;
        grant_done  = mem_req_o && mem_gnt_i;
        gnt_o       = grant_done ? (N_REQ'(1) << sel_idx) : '0;
        push        = grant_done;
        pop         = !rst_i && mem_rvalid_i && !fifo_empty;
        rvalid_o    = pop ? (N_REQ'(1) << fifo_q[rd_q]) : '0;
    end

    assign rdata_o = mem_rdata_i;
    assign busy_o  = !fifo_empty;
    assign err_o   = err_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_ARB: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = ST_LOCK;
                    sel_d   = win_idx;
                end
            end
            ST_LOCK: begin
                if (grant_done) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
        if (grant_done) ptr_d = IW'((int'(sel_idx) + 1) % N_REQ);
    end

    always_comb begin
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        err_d = err_q || (mem_rvalid_i && fifo_empty) || (mem_gnt_i && !mem_req_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ARB;
            sel_q   <= '0;
            ptr_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
        end
    end

    // ID storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_q] <= sel_idx;
    end

`ifdef MEM_ARB_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if ((|req_i) && !grant_done && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter that shares one 32-bit request/response memory port among the CGRA input-node readers and output-node writers. It sits between the per-node streaming state machines and the single AXI-Lite master adapter. It also tracks outstanding transactions so that in-order responses are routed back to the requester that issued them.

## Interface

Parameters:
- N_REQ, 8, number of requesters (input nodes 0-3 at indices 0-3, output nodes 0-3 at indices 4-7); range 2..16.
- MAX_OUT, 4, maximum outstanding granted-but-unanswered transactions; power of two, range 1..16.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  N_REQ  per-requester request.
- we_i  in  N_REQ  per-requester write enable.
- addr_i  in  N_REQ×32  per-requester word address.
- wdata_i  in  N_REQ×32  per-requester write data.
- gnt_o  out  N_REQ  per-requester grant (one-hot or zero).
- rvalid_o  out  N_REQ  per-requester response valid (one-hot or zero).
- rdata_o  out  32  response data, broadcast to all requesters.
- mem_req_o  out  1  downstream request.
- mem_we_o  out  1  downstream write enable.
- mem_addr_o  out  32  downstream address.
- mem_wdata_o  out  32  downstream write data.
- mem_gnt_i  in  1  downstream accepts the request this cycle.
- mem_rvalid_i  in  1  downstream response valid; responses return in order.
- mem_rdata_i  in  32  downstream read data; don't-care for writes.
- busy_o  out  1  outstanding count is nonzero.
- err_o  out  1  sticky protocol error.

## Operation

Requester protocol:
- Once a requester raises req_i[i], it must hold req_i, we_i, addr_i and wdata_i stable until gnt_o[i] is high.
- The handshake completes on a cycle with req and gnt both high.

Arbitration:
- Priority pointer ptr_q has width clog2(N_REQ) and resets to 0.
- Priority order is ptr_q, ptr_q+1, … modulo N_REQ.
- The winner is the first requester in that order with req_i set.
- On a completed grant to index k, ptr_q becomes (k+1) mod N_REQ.

Lock:
- Two states: ARB and LOCK.
- In ARB, if mem_req_o is high and mem_gnt_i is low, the winner index is latched into sel_q and the state moves to LOCK.
- In LOCK, the mux drives sel_q regardless of other requests. On mem_gnt_i the state returns to ARB.
- This keeps the downstream request stable until it is accepted.

Mux:
- mem_req_o = selected req_i & ~fifo_full.
- mem_we_o, mem_addr_o and mem_wdata_o come from the selected requester. They are 0 when no requester is selected.
- gnt_o[sel] = mem_gnt_i & mem_req_o.

ID FIFO:
- Depth MAX_OUT; each entry is clog2(N_REQ) bits.
- A completed downstream grant pushes the selected index.
- mem_rvalid_i pops the head and sets rvalid_o[head]. rdata_o = mem_rdata_i.
- Push and pop in the same cycle are both performed; the count is unchanged.
- When the FIFO is full, no new grant is issued (mem_req_o = 0), even if a pop occurs in the same cycle.

Errors:
- mem_rvalid_i while the FIFO is empty sets err_o. No rvalid_o is raised.
- mem_gnt_i while mem_req_o is low is ignored and also sets err_o.
- err_o clears only on reset.

## Timing

- Grant path is combinational: from req_i to mem_req_o, and from mem_gnt_i to gnt_o, with zero cycles of latency.
- Response path is combinational: from mem_rvalid_i to rvalid_o.
- The pointer, state, FIFO and error flag update on the clock edge following the event.
- Reset values: ptr_q = 0, state = ARB, FIFO empty, err_o = 0, busy_o = 0.
- While rst_i is high, mem_req_o, gnt_o and rvalid_o are forced to 0.
- Reset mid-transaction discards the outstanding IDs. Late responses after reset set err_o.
- Throughput: one grant per cycle when mem_gnt_i is held high and the FIFO is not full.
- A single active requester is granted back to back. The pointer moves past it and wraps back to it.
- Wrap-around: from ptr_q = N_REQ-1 the search continues at index 0.

## Configuration

- Macro MEM_ARB_STALL_CNT_EN.
- Defined: adds output port stall_cnt_o, 32 bits, reset to 0. It increments on every cycle in which any req_i is high and no grant completes. It saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan

- Reset, then req_i=0x01, addr 0x80000000 read, mem_gnt_i=1: gnt_o=0x01 in the same cycle. A response 2 cycles later with rdata 0xDEADBEEF gives rvalid_o=0x01 and rdata_o=0xDEADBEEF. busy_o falls after the response.
- All 8 requesters held with mem_gnt_i=1 and immediate responses: grants occur in the order 0,1,…,7,0. Each index is granted exactly once per 8 cycles.
- req_i=0x24 with mem_gnt_i low for 3 cycles: mem_addr_o stays on index 2 throughout (LOCK). Raising req_i[1] during the stall does not change it. On gnt, index 2 is granted, then index 5.
- MAX_OUT=4, 4 grants with no responses: the 5th request sees mem_req_o=0. A response to index 3 with a simultaneous request keeps mem_req_o=0 that cycle; the grant comes on the next cycle.
- mem_rvalid_i with an empty FIFO gives err_o=1 and rvalid_o=0. err_o stays 1 until rst_i is pulsed.
- With MEM_ARB_STALL_CNT_EN defined: req_i=0x01 and mem_gnt_i low for 10 cycles gives stall_cnt_o=10.
